// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared stage indices, forward-select encodings and dest-track type
package mycpu_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Destination info carried alongside an in-flight instruction
  typedef struct packed {
    logic [REG_AW_DEF-1:0] dest;
    logic                  we;
    logic                  load;
  } dest_trk_t;

  // A tracked stage produces a value the ID source needs; $0 never matches
  function automatic logic trk_match(input dest_trk_t trk, input logic vld,
                                     input logic [REG_AW_DEF-1:0] src, input logic used);
    return used && (src != '0) && vld && trk.we && (trk.dest == src);
  endfunction

endpackage

// File: rtl/mycpu_hazard_unit.sv
// rtl/mycpu_hazard_unit.sv - RAW match, ID stall and forward select (MYCPU_PIPE_FWD_EN)
module mycpu_hazard_unit
  import mycpu_pkg::*;
(
  input  logic [REG_AW_DEF-1:0] id_rs_i,
  input  logic [REG_AW_DEF-1:0] id_rt_i,
  input  logic                  id_rs_used_i,
  input  logic                  id_rt_used_i,
  input  logic                  exe_valid_i,
  input  logic                  mem_valid_i,
  input  logic                  wb_valid_i,
  input  dest_trk_t             exe_trk_i,
  input  dest_trk_t             mem_trk_i,
  input  dest_trk_t             wb_trk_i,
`ifdef MYCPU_PIPE_FWD_EN
  output logic [1:0]            fwd_rs_sel_o,
  output logic [1:0]            fwd_rt_sel_o,
`endif
  output logic                  hazard_o
);

  logic rs_exe, rs_mem, rs_wb, rt_exe, rt_mem, rt_wb;

  // Per-stage source matches against tracked destinations
  always_comb begin
    rs_exe = trk_match(exe_trk_i, exe_valid_i, id_rs_i, id_rs_used_i);
    rs_mem = trk_match(mem_trk_i, mem_valid_i, id_rs_i, id_rs_used_i);
    rs_wb  = trk_match(wb_trk_i,  wb_valid_i,  id_rs_i, id_rs_used_i);
    rt_exe = trk_match(exe_trk_i, exe_valid_i, id_rt_i, id_rt_used_i);
    rt_mem = trk_match(mem_trk_i, mem_valid_i, id_rt_i, id_rt_used_i);
    rt_wb  = trk_match(wb_trk_i,  wb_valid_i,  id_rt_i, id_rt_used_i);
  end

`ifdef MYCPU_PIPE_FWD_EN
  // Nearest producer wins; only a load still in EXE cannot be bypassed
  always_comb begin
    fwd_rs_sel_o = rs_exe ? FWD_EXE : rs_mem ? FWD_MEM : rs_wb ? FWD_WB : FWD_RF;
    fwd_rt_sel_o = rt_exe ? FWD_EXE : rt_mem ? FWD_MEM : rt_wb ? FWD_WB : FWD_RF;
    hazard_o     = exe_trk_i.load && (rs_exe || rt_exe);
  end
`else
  // Without bypass any older writer of a source must retire first
  always_comb begin
    hazard_o = rs_exe || rs_mem || rs_wb || rt_exe || rt_mem || rt_wb;
  end
`endif

endmodule

// File: rtl/mycpu_pipe_ctrl.sv
// rtl/mycpu_pipe_ctrl.sv - 5-stage valid/allowin sequencer with RAW stall (MYCPU_PIPE_FWD_EN)
module mycpu_pipe_ctrl
  import mycpu_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_ready_go,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   id_we,
  input  logic                   id_is_load,
  input  logic                   id_br_taken,
  input  logic                   exe_busy,
  output logic                   pc_en,
  output logic                   jen_out,
  output logic                   if_to_id_en,
  output logic                   id_to_exe_en,
  output logic                   exe_to_mem_en,
  output logic                   mem_to_wb_en,
  output logic                   id_valid,
  output logic                   exe_valid,
  output logic                   mem_valid,
  output logic                   wb_valid,
  output logic                   rf_wen_q,
`ifdef MYCPU_PIPE_FWD_EN
  output logic [1:0]             fwd_rs_sel,
  output logic [1:0]             fwd_rt_sel,
`endif
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [STG_WB:STG_ID]   valid_q, valid_d;
  dest_trk_t              trk_exe_q, trk_exe_d, trk_mem_q, trk_mem_d, trk_wb_q, trk_wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hazard;
  logic                   id_ready_go, exe_ready_go, mem_ready_go;
  logic                   id_allowin, exe_allowin, mem_allowin, wb_allowin;

  mycpu_hazard_unit u_hazard (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rs_used_i (id_rs_used),
    .id_rt_used_i (id_rt_used),
    .exe_valid_i  (valid_q[STG_EXE]),
    .mem_valid_i  (valid_q[STG_MEM]),
    .wb_valid_i   (valid_q[STG_WB]),
    .exe_trk_i    (trk_exe_q),
    .mem_trk_i    (trk_mem_q),
    .wb_trk_i     (trk_wb_q),
`ifdef MYCPU_PIPE_FWD_EN
    .fwd_rs_sel_o (fwd_rs_sel),
    .fwd_rt_sel_o (fwd_rt_sel),
`endif
    .hazard_o     (hazard)
  );

  // Handshake chain, transfer enables and next-state of valids, tracking and counter
  always_comb begin
    id_ready_go   = !hazard;
    exe_ready_go  = !exe_busy;
    mem_ready_go  = 1'b1;
    wb_allowin    = 1'b1;
    mem_allowin   = !valid_q[STG_MEM] || (mem_ready_go && wb_allowin);
    exe_allowin   = !valid_q[STG_EXE] || (exe_ready_go && mem_allowin);
    id_allowin    = !valid_q[STG_ID]  || (id_ready_go  && exe_allowin);

    if_to_id_en   = if_ready_go && id_allowin;
    id_to_exe_en  = valid_q[STG_ID]  && id_ready_go  && exe_allowin;
    exe_to_mem_en = valid_q[STG_EXE] && exe_ready_go && mem_allowin;
    mem_to_wb_en  = valid_q[STG_MEM] && mem_ready_go && wb_allowin;

    pc_en         = if_ready_go && id_allowin;
    jen_out       = valid_q[STG_ID] && id_br_taken && id_ready_go && exe_allowin;

    valid_d          = valid_q;
    valid_d[STG_ID]  = id_allowin  ? if_to_id_en   : valid_q[STG_ID];
    valid_d[STG_EXE] = exe_allowin ? id_to_exe_en  : valid_q[STG_EXE];
    valid_d[STG_MEM] = mem_allowin ? exe_to_mem_en : valid_q[STG_MEM];
    valid_d[STG_WB]  = wb_allowin  ? mem_to_wb_en  : valid_q[STG_WB];

    trk_exe_d = id_to_exe_en  ? {id_dest, id_we, id_is_load} : trk_exe_q;
    trk_mem_d = exe_to_mem_en ? trk_exe_q : trk_mem_q;
    trk_wb_d  = mem_to_wb_en  ? trk_mem_q : trk_wb_q;

    stall_cnt_d = stall_cnt_q;
    if (valid_q[STG_ID] && !id_ready_go && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    id_valid  = valid_q[STG_ID];
    exe_valid = valid_q[STG_EXE];
    mem_valid = valid_q[STG_MEM];
    wb_valid  = valid_q[STG_WB];
    rf_wen_q  = valid_q[STG_WB] && trk_wb_q.we;
    stall_cnt = stall_cnt_q;
  end

  // Pipeline state registers; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      trk_exe_q   <= '0;
      trk_mem_q   <= '0;
      trk_wb_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      trk_exe_q   <= trk_exe_d;
      trk_mem_q   <= trk_mem_d;
      trk_wb_q    <= trk_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
